// File: rtl/carregador_programa.sv
// Program loader: takes a byte stream (header word count, little-endian data
// words, XOR checksum) and emits one instruction-memory write per assembled word.
module carregador_programa #(
    parameter logic [7:0] BASE = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicio,
    input  logic [7:0]  byte_in,
    input  logic        byte_valido,
    output logic        byte_pronto,
    output logic        mem_we,
    output logic [7:0]  mem_endereco,
    output logic [31:0] mem_dado,
    output logic        ocupado,
    output logic        concluido,
    output logic        erro
);

    localparam logic [2:0] OCIOSO    = 3'd0;
    localparam logic [2:0] CABECALHO = 3'd1;
    localparam logic [2:0] DADOS     = 3'd2;
    localparam logic [2:0] ESCRITA   = 3'd3;
    localparam logic [2:0] CHECKSUM  = 3'd4;
    localparam logic [2:0] FIM       = 3'd5;

    logic [2:0]  estado_reg;
    logic [8:0]  total_reg;     // word count, 1..256
    logic [8:0]  indice_reg;
    logic [1:0]  cont_reg;
    logic [23:0] palavra_reg;   // lower three bytes of the word being assembled
    logic [7:0]  soma_reg;
    logic        erro_reg;
    logic [7:0]  endereco_reg;
    logic [31:0] dado_reg;
    logic        aceita;

    assign byte_pronto  = (estado_reg == CABECALHO) || (estado_reg == DADOS) ||
                          (estado_reg == CHECKSUM);
    assign aceita       = byte_valido && byte_pronto;
    assign mem_we       = (estado_reg == ESCRITA);
    assign ocupado      = (estado_reg != OCIOSO);
    assign concluido    = (estado_reg == FIM);
    assign erro         = erro_reg;
    assign mem_endereco = endereco_reg;
    assign mem_dado     = dado_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg   <= OCIOSO;
            total_reg    <= 9'd0;
            indice_reg   <= 9'd0;
            cont_reg     <= 2'd0;
            palavra_reg  <= 24'd0;
            soma_reg     <= 8'd0;
            erro_reg     <= 1'b0;
            endereco_reg <= 8'd0;
            dado_reg     <= 32'd0;
        end else begin
            case (estado_reg)
                OCIOSO: begin
                    if (inicio) begin
                        estado_reg <= CABECALHO;
                        erro_reg   <= 1'b0;
                        indice_reg <= 9'd0;
                        cont_reg   <= 2'd0;
                        soma_reg   <= 8'd0;
                    end
                end
                CABECALHO: begin
                    if (aceita) begin
                        total_reg  <= (byte_in == 8'd0) ? 9'd256 : {1'b0, byte_in};
                        soma_reg   <= soma_reg ^ byte_in;
                        estado_reg <= DADOS;
                    end
                end
                DADOS: begin
                    if (aceita) begin
                        soma_reg <= soma_reg ^ byte_in;
                        cont_reg <= cont_reg + 2'd1;
                        // Output registers are loaded here so they are valid for the ESCRITA cycle
                        if (cont_reg == 2'd3) begin
                            endereco_reg <= BASE + indice_reg[7:0];
                            dado_reg     <= {byte_in, palavra_reg};
                            estado_reg   <= ESCRITA;
                        end else begin
                            palavra_reg[8*cont_reg +: 8] <= byte_in;
                        end
                    end
                end
                ESCRITA: begin
                    indice_reg <= indice_reg + 9'd1;
                    estado_reg <= (indice_reg + 9'd1 == total_reg) ? CHECKSUM : DADOS;
                end
                CHECKSUM: begin
                    if (aceita) begin
                        erro_reg   <= (byte_in != soma_reg);
                        estado_reg <= FIM;
                    end
                end
                FIM: begin
                    estado_reg <= OCIOSO;
                end
                default: begin
                    estado_reg <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa: two instances (BASE=0 and BASE=FE)
// share one stimulus stream; writes are captured and compared per load.
module tb_carregador_programa;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inicio = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valido = 1'b0;

    logic        pr0, we0, oc0, co0, er0;
    logic [7:0]  ad0;
    logic [31:0] da0;
    logic        pr1, we1, oc1, co1, er1;
    logic [7:0]  ad1;
    logic [31:0] da1;

    int checks = 0;
    int errors = 0;
    int conc0 = 0;
    int conc1 = 0;
    logic [39:0] wr0[$];
    logic [39:0] wr1[$];
    logic [7:0]  dat[1024];

    always #5 clk = ~clk;

    carregador_programa #(.BASE(8'h00)) u0 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .byte_in(byte_in),
        .byte_valido(byte_valido), .byte_pronto(pr0), .mem_we(we0),
        .mem_endereco(ad0), .mem_dado(da0), .ocupado(oc0),
        .concluido(co0), .erro(er0)
    );

    carregador_programa #(.BASE(8'hFE)) u1 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .byte_in(byte_in),
        .byte_valido(byte_valido), .byte_pronto(pr1), .mem_we(we1),
        .mem_endereco(ad1), .mem_dado(da1), .ocupado(oc1),
        .concluido(co1), .erro(er1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write/pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (we0) begin
            wr0.push_back({ad0, da0});
            check("pronto_in_escrita_u0", 64'(pr0), 64'd0);
        end
        if (we1) begin
            wr1.push_back({ad1, da1});
            check("pronto_in_escrita_u1", 64'(pr1), 64'd0);
        end
        if (co0) conc0++;
        if (co1) conc1++;
    end

    task automatic idle(input int n);
        byte_valido = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Presents a byte and keeps byte_valido high until it is accepted
    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_valido = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (pr0) begin
                @(posedge clk);
                @(negedge clk);
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] hdr, input int nb);
        logic [7:0] x;
        x = hdr;
        for (int i = 0; i < nb; i++) x = x ^ dat[i];
        return x;
    endfunction

    task automatic run_load(input string tag, input logic [7:0] hdr, input int nw,
                            input logic [7:0] csum, input bit gap, input int ign_at,
                            input logic exp_err);
        int t;
        logic [7:0]  a0, a1;
        logic [31:0] d;
        wr0.delete();
        wr1.delete();
        conc0 = 0;
        conc1 = 0;
        inicio = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        check({tag, "_ocupado"}, 64'(oc0), 64'd1);
        check({tag, "_erro_clr"}, 64'(er0), 64'd0);
        send_byte(hdr);
        if (gap) idle(1);
        for (int i = 0; i < nw * 4; i++) begin
            send_byte(dat[i]);
            if (gap) idle(1);
            if (i == ign_at) begin
                byte_valido = 1'b0;
                inicio = 1'b1;
                @(posedge clk);
                @(negedge clk);
                inicio = 1'b0;
            end
        end
        send_byte(csum);
        byte_valido = 1'b0;
        t = 0;
        while (oc0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done"}, 64'(oc0), 64'd0);
        @(negedge clk);
        check({tag, "_nwr_u0"}, 64'(wr0.size()), 64'(nw));
        check({tag, "_nwr_u1"}, 64'(wr1.size()), 64'(nw));
        for (int w = 0; w < nw; w++) begin
            a0 = 8'(w);
            a1 = 8'(8'hFE + w);
            d  = {dat[4*w+3], dat[4*w+2], dat[4*w+1], dat[4*w]};
            if (w < wr0.size()) check({tag, "_wr_u0"}, 64'(wr0[w]), 64'({a0, d}));
            if (w < wr1.size()) check({tag, "_wr_u1"}, 64'(wr1[w]), 64'({a1, d}));
        end
        check({tag, "_concluido_u0"}, 64'(conc0), 64'd1);
        check({tag, "_concluido_u1"}, 64'(conc1), 64'd1);
        check({tag, "_erro_u0"}, 64'(er0), 64'(exp_err));
        check({tag, "_erro_u1"}, 64'(er1), 64'(exp_err));
        $display("load %s: hdr=%02h words=%0d writes=%0d erro=%0b", tag, hdr, nw, wr0.size(), er0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ocupado", 64'(oc0), 64'd0);
        check("rst_pronto", 64'(pr0), 64'd0);
        check("rst_we", 64'(we0), 64'd0);
        check("rst_concluido", 64'(co0), 64'd0);
        check("rst_erro", 64'(er0), 64'd0);
        check("rst_addr", 64'(ad0), 64'd0);
        check("rst_data", 64'(da0), 64'd0);
        check("rst_addr_u1", 64'(ad1), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, correct checksum, spurious inicio mid-load
        dat[0] = 8'h83; dat[1] = 8'h20; dat[2] = 8'h00; dat[3] = 8'h00;
        run_load("t1_single", 8'h01, 1, 8'hA2, 1'b1, 1, 1'b0);

        // Same stream, bad checksum; erro must persist while idle
        run_load("t2_badsum", 8'h01, 1, 8'hA3, 1'b0, -1, 1'b1);
        idle(3);
        check("t2_erro_hold_u0", 64'(er0), 64'd1);
        check("t2_erro_hold_u1", 64'(er1), 64'd1);

        // Three words with gaps; u1 wraps FE, FF, 00
        for (int i = 0; i < 12; i++) dat[i] = 8'(8'h10 + 8'(i * 17));
        run_load("t3_wrap", 8'h03, 3, xsum(8'h03, 12), 1'b1, -1, 1'b0);

        // Two words with byte_valido held high throughout
        for (int i = 0; i < 8; i++) dat[i] = 8'(8'hC5 ^ 8'(i * 29));
        run_load("t4_stream", 8'h02, 2, xsum(8'h02, 8), 1'b0, -1, 1'b0);

        // Reset after the second data byte aborts the load
        wr0.delete();
        wr1.delete();
        inicio = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        byte_valido = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ocupado", 64'(oc0), 64'd0);
        check("t5_rst_pronto", 64'(pr0), 64'd0);
        check("t5_rst_addr", 64'(ad0), 64'd0);
        check("t5_rst_data", 64'(da0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        byte_in = 8'h33;
        byte_valido = 1'b1;
        repeat (4) @(negedge clk);
        byte_valido = 1'b0;
        check("t5_no_write_u0", 64'(wr0.size()), 64'd0);
        check("t5_no_write_u1", 64'(wr1.size()), 64'd0);
        check("t5_idle", 64'(oc0), 64'd0);
        $display("load t5_abort: reset mid-load writes=%0d ocupado=%0b", wr0.size(), oc0);

        // Full load after the abort
        dat[0] = 8'h83; dat[1] = 8'h20; dat[2] = 8'h00; dat[3] = 8'h00;
        run_load("t6_after_rst", 8'h01, 1, 8'hA2, 1'b0, -1, 1'b0);

        // Header 00 means 256 words
        for (int i = 0; i < 1024; i++) dat[i] = 8'((i * 7 + 3) ^ (i >> 8));
        run_load("t7_256", 8'h00, 256, xsum(8'h00, 1024), 1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carregador_programa.md
CARREGADOR_PROGRAMA -- requirements
Module: carregador_programa

Interface
REQ-001 The block SHALL have parameter BASE, default 8'd0, meaning the first word index written into instruction memory.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 inicio  input  1  start pulse; sampled only in state OCIOSO.
REQ-006 byte_in  input  8  incoming load-stream byte.
REQ-007 byte_valido  input  1  byte_in is valid this cycle.
REQ-008 byte_pronto  output  1  block accepts a byte this cycle.
REQ-009 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 mem_endereco  output  8  word index for the write.
REQ-011 mem_dado  output  32  assembled instruction word.
REQ-012 ocupado  output  1  load in progress (any state except OCIOSO).
REQ-013 concluido  output  1  one-cycle pulse at end of load.
REQ-014 erro  output  1  checksum mismatch flag.

Function
REQ-015 The block SHALL implement states OCIOSO, CABECALHO, DADOS, ESCRITA, CHECKSUM and FIM.
REQ-016 A byte SHALL be accepted on a rising edge only when byte_valido=1 and byte_pronto=1.
REQ-017 byte_pronto SHALL be 1 only in CABECALHO, DADOS and CHECKSUM; it SHALL be 0 elsewhere.
REQ-018 From OCIOSO, inicio=1 SHALL move to CABECALHO next cycle, clear erro, word index, byte counter and running checksum.
REQ-019 The block SHALL ignore inicio in every state other than OCIOSO.
REQ-020 In CABECALHO, the accepted byte SHALL set word count N, with 0 meaning 256 words, and SHALL move to DADOS.
REQ-021 In DADOS, accepted bytes SHALL fill the word little-endian: first byte into [7:0], then [15:8], [23:16] and [31:24].
REQ-022 After the fourth byte of a word, the state SHALL be ESCRITA for exactly one cycle.
REQ-023 In ESCRITA, mem_we SHALL be 1, mem_endereco SHALL be (BASE + index) mod 256, and mem_dado SHALL be the assembled word.
REQ-024 On leaving ESCRITA, index SHALL increment; the next state SHALL be CHECKSUM if index+1 = N, otherwise DADOS.
REQ-025 The running checksum SHALL be the 8-bit XOR of the header and every data byte accepted.
REQ-026 In CHECKSUM, the accepted byte SHALL be compared to the running checksum; erro SHALL be set to 1 on mismatch, and the state SHALL move to FIM.
REQ-027 In FIM, concluido SHALL be 1 for exactly one cycle, then the state SHALL return to OCIOSO.
REQ-028 erro SHALL hold its value until the next accepted inicio or reset.
REQ-029 mem_we SHALL be 0 in every state except ESCRITA; mem_endereco and mem_dado SHALL hold their last written values otherwise.
REQ-030 byte_valido held high with byte_pronto=0 SHALL cause no acceptance and no loss of already assembled bytes.
REQ-031 Address SHALL wrap from 255 to 0 when BASE + index exceeds 255.
REQ-032 With N=0, exactly 256 words SHALL be written before CHECKSUM.

Reset
REQ-033 On rst_n=0, the block SHALL immediately enter OCIOSO and set mem_we, byte_pronto, concluido, erro and ocupado to 0, mem_endereco to 0 and mem_dado to 0.
REQ-034 Reset asserted mid-load SHALL abort the load with no further write and no partial word written; a new inicio SHALL be required.

Verification
REQ-035 BASE=0: inicio, then bytes 01,83,20,00,00,A2 -> one write, addr 0x00, data 0x00002083; concluido pulse; erro=0.
REQ-036 Same stream with checksum byte A3 -> identical write; concluido pulse; erro=1 until next inicio.
REQ-037 BASE=8'hFE, N=3, 12 data bytes plus correct checksum -> writes at 0xFE, 0xFF, 0x00 in order; one write per four bytes.
REQ-038 byte_valido held high continuously during N=2 load -> byte_pronto=0 during each ESCRITA cycle; no byte lost or duplicated; words correct.
REQ-039 rst_n pulsed low after the second data byte -> mem_we never asserts; ocupado=0; inicio pulses during the load ignored; subsequent full load succeeds.
REQ-040 Header 00 followed by 1024 data bytes and correct checksum -> 256 writes covering addresses BASE..BASE+255 mod 256, then concluido.
